// File: rtl/fn4_vector_checker_if.sv
// ----------------------------------------------------------------------------
// fn4_vector_checker_if
// Groups the stimulus/response and result signals of the vector checker.
//   start           request to begin a sweep (single cycle)
//   y               output of the function under test
//   a, b, c, d      stimulus to the function under test (a is the MSB)
//   busy, done      sweep in progress / one-cycle end-of-sweep pulse
//   pass            last sweep had zero mismatches
//   fail_count      mismatches in the last sweep (0..16)
//   first_fail      lowest failing vector index, valid with first_fail_vld
//   response        captured y per vector index
// master: the checker itself.  slave: the environment (start source + DUT).
// ----------------------------------------------------------------------------
interface fn4_vector_checker_if;
   logic        start;
   logic        y;
   logic        a;
   logic        b;
   logic        c;
   logic        d;
   logic        busy;
   logic        done;
   logic        pass;
   logic [4:0]  fail_count;
   logic [3:0]  first_fail;
   logic        first_fail_vld;
   logic [15:0] response;

   modport master (
      input  start, y,
      output a, b, c, d, busy, done, pass,
             fail_count, first_fail, first_fail_vld, response
   );

   modport slave (
      output start, y,
      input  a, b, c, d, busy, done, pass,
             fail_count, first_fail, first_fail_vld, response
   );
endinterface

// File: rtl/fn4_vector_checker.sv
// ----------------------------------------------------------------------------
// fn4_vector_checker
// Exhaustive self-test sequencer for a 4-input combinational function.
// Drives vectors 0..15 on {a,b,c,d}, holds each for SETTLE cycles, samples y,
// compares against the EXPECTED truth table and reports the results.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   fn4_vector_checker_if.master (start/y in; stimulus and results out)
// Parameters:
//   EXPECTED  golden truth table, bit i = expected y for vector i
//   SETTLE    hold cycles before sampling (1..15)
// Build option:
//   FN4_CHECK_STOP_ON_FAIL_EN  defined: the first mismatch ends the sweep
// ----------------------------------------------------------------------------
module fn4_vector_checker #(
   parameter logic [15:0] EXPECTED = 16'h0DD0,
   parameter int unsigned SETTLE   = 2
) (
   input logic                   clk,
   input logic                   rst,
   fn4_vector_checker_if.master  bus
);

   localparam int unsigned VEC_W = 4;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned FC_W  = 5;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(15);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   state_t            state_q, state_d;
   logic [VEC_W-1:0]  vec_q, vec_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [FC_W-1:0]   fail_count_d;
   logic [VEC_W-1:0]  first_fail_d;
   logic              first_fail_vld_d;
   logic [15:0]       response_d;
   logic              pass_d;
   logic              mismatch;
   logic              last_vec;

   // Next-state and next-result logic
   always_comb begin
      state_d          = state_q;
      vec_d            = vec_q;
      cnt_d            = cnt_q;
      fail_count_d     = bus.fail_count;
      first_fail_d     = bus.first_fail;
      first_fail_vld_d = bus.first_fail_vld;
      response_d       = bus.response;
      pass_d           = bus.pass;
      mismatch         = 1'b0;
      last_vec         = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               vec_d            = '0;
               cnt_d            = '0;
               fail_count_d     = '0;
               first_fail_d     = '0;
               first_fail_vld_d = 1'b0;
               response_d       = '0;
               pass_d           = 1'b0;
               state_d          = DRIVE;
            end
         end
         DRIVE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == SETTLE_LAST) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            response_d[vec_q] = bus.y;
            mismatch          = (bus.y != EXPECTED[vec_q]);
            if (mismatch) begin
               fail_count_d = bus.fail_count + FC_W'(1);
               if (!bus.first_fail_vld) begin
                  first_fail_d     = vec_q;
                  first_fail_vld_d = 1'b1;
               end
            end
`ifdef FN4_CHECK_STOP_ON_FAIL_EN
            last_vec = mismatch || (vec_q == VEC_LAST);
`else
            last_vec = (vec_q == VEC_LAST);
`endif
            if (last_vec) begin
               // pass is registered on entry so it is valid alongside done
               pass_d  = (fail_count_d == '0);
               state_d = DONE;
            end else begin
               vec_d   = vec_q + VEC_W'(1);
               cnt_d   = '0;
               state_d = DRIVE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q                        <= IDLE;
         vec_q                          <= '0;
         cnt_q                          <= '0;
         {bus.a, bus.b, bus.c, bus.d}   <= '0;
         bus.busy                       <= 1'b0;
         bus.done                       <= 1'b0;
         bus.pass                       <= 1'b0;
         bus.fail_count                 <= '0;
         bus.first_fail                 <= '0;
         bus.first_fail_vld             <= 1'b0;
         bus.response                   <= '0;
      end else begin
         state_q            <= state_d;
         vec_q              <= vec_d;
         cnt_q              <= cnt_d;
         // Stimulus trails vec by one cycle, so each vector is held SETTLE cycles before sampling
         {bus.a, bus.b, bus.c, bus.d} <= ((state_q == DRIVE) || (state_q == SAMPLE)) ? vec_q : '0;
         bus.busy           <= (state_d != IDLE);
         bus.done           <= (state_d == DONE);
         bus.pass           <= pass_d;
         bus.fail_count     <= fail_count_d;
         bus.first_fail     <= first_fail_d;
         bus.first_fail_vld <= first_fail_vld_d;
         bus.response       <= response_d;
      end
   end

endmodule

// File: tb/tb_fn4_vector_checker.sv
// ----------------------------------------------------------------------------
// tb_fn4_vector_checker
// Drives fn4_vector_checker against a table-driven function under test and
// checks timing and results against a reference computed from the golden
// function F = (A xor B) and (C or not D).
// ----------------------------------------------------------------------------
module tb_fn4_vector_checker;

   localparam int unsigned S = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] fut_tt;
   int          tests = 0;
   int          fails = 0;

   fn4_vector_checker_if ifc ();

   // Function under test: combinational lookup of the current stimulus
   assign ifc.y = fut_tt[{ifc.a, ifc.b, ifc.c, ifc.d}];

   fn4_vector_checker #(.EXPECTED(16'h0DD0), .SETTLE(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] golden_table();
      logic [15:0] t;
      logic        fa, fb, fc, fd;
      for (int i = 0; i < 16; i++) begin
         fa   = ((i >> 3) & 1) != 0;
         fb   = ((i >> 2) & 1) != 0;
         fc   = ((i >> 1) & 1) != 0;
         fd   = (i & 1) != 0;
         t[i] = (fa ^ fb) & (fc | ~fd);
      end
      return t;
   endfunction

   task automatic check_reset_vals(input string ctx);
      check({ctx, "_abcd"},  32'({ifc.a, ifc.b, ifc.c, ifc.d}), 0);
      check({ctx, "_busy"},  32'(ifc.busy), 0);
      check({ctx, "_done"},  32'(ifc.done), 0);
      check({ctx, "_pass"},  32'(ifc.pass), 0);
      check({ctx, "_fcnt"},  32'(ifc.fail_count), 0);
      check({ctx, "_ff"},    32'(ifc.first_fail), 0);
      check({ctx, "_ffvld"}, 32'(ifc.first_fail_vld), 0);
      check({ctx, "_resp"},  32'(ifc.response), 0);
   endtask

   // One sweep against table tt; poke re-pulses start mid-sweep and during DONE
   task automatic run_sweep(input string name, input logic [15:0] tt, input bit poke);
      logic [15:0] gt;
      logic [15:0] exp_resp;
      int          mism;
      int          ff;
      int          last;
      int          n_done;
      int          k;
      bit          seen;

      gt       = golden_table();
      exp_resp = '0;
      mism     = 0;
      ff       = -1;
      last     = 15;
      for (int i = 0; i < 16; i++) begin
         exp_resp[i] = tt[i];
         if (tt[i] != gt[i]) begin
            mism++;
            if (ff < 0) ff = i;
`ifdef FN4_CHECK_STOP_ON_FAIL_EN
            last = i;
            break;
`endif
         end
      end
      n_done = (last + 1) * int'(S + 1);

      fut_tt = tt;
      @(negedge clk) ifc.start = 1'b1;
      @(posedge clk);
      @(negedge clk) ifc.start = 1'b0;

      k    = 0;
      seen = 1'b0;
      while (k < 200 && !seen) begin
         @(posedge clk);
         #1;
         k++;
         if (k == 1) check({name, "_busy_rise"}, 32'(ifc.busy), 1);
         if (((k - 1) % int'(S + 1)) == 0 && ((k - 1) / int'(S + 1)) <= last)
            check({name, "_vec_drive"}, 32'({ifc.a, ifc.b, ifc.c, ifc.d}), 32'((k - 1) / int'(S + 1)));
         if (poke && k == 1 + 3 * int'(S + 1)) ifc.start = 1'b1;
         if (poke && k == 2 + 3 * int'(S + 1)) ifc.start = 1'b0;
         if (ifc.done) seen = 1'b1;
      end

      check({name, "_done_edge"}, 32'(k),                  32'(n_done));
      check({name, "_pass"},      32'(ifc.pass),           32'(mism == 0));
      check({name, "_fcnt"},      32'(ifc.fail_count),     32'(mism));
      check({name, "_ff"},        32'(ifc.first_fail),     32'(ff < 0 ? 0 : ff));
      check({name, "_ffvld"},     32'(ifc.first_fail_vld), 32'(ff >= 0));
      check({name, "_resp"},      32'(ifc.response),       32'(exp_resp));

      if (poke) ifc.start = 1'b1;
      @(posedge clk);
      #1;
      ifc.start = 1'b0;
      check({name, "_done_pulse"}, 32'(ifc.done), 0);
      check({name, "_busy_fall"},  32'(ifc.busy), 0);
      @(posedge clk);
      #1;
      check({name, "_no_restart"}, 32'(ifc.busy),       0);
      check({name, "_hold_fcnt"},  32'(ifc.fail_count), 32'(mism));
      check({name, "_hold_resp"},  32'(ifc.response),   32'(exp_resp));
   endtask

   initial begin
      int k;

      rst       = 1'b1;
      ifc.start = 1'b0;
      fut_tt    = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("por");
      @(negedge clk) rst = 1'b0;

      run_sweep("correct",  golden_table(),  1'b0);
      run_sweep("stuck0",   16'h0000,        1'b0);
      run_sweep("inverted", ~golden_table(), 1'b0);

      // Reset while vector 7 is on the stimulus lines
      fut_tt = golden_table();
      @(negedge clk) ifc.start = 1'b1;
      @(posedge clk);
      @(negedge clk) ifc.start = 1'b0;
      k = 0;
      while (k < 1 + 7 * int'(S + 1)) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("mid_vec7", 32'({ifc.a, ifc.b, ifc.c, ifc.d}), 7);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals("mid_rst");
      rst = 1'b0;

      run_sweep("after_rst", golden_table(), 1'b0);
      run_sweep("poke", golden_table() ^ 16'h1000, 1'b1);

      for (int r = 0; r < 4; r++) begin
         run_sweep($sformatf("random%0d", r), 16'($urandom), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fn4_vector_checker.md
# fn4_vector_checker

Sequential self-test sequencer for the 4-input combinational function blocks of chapter 3. It drives every input combination {a,b,c,d} into the function under test, samples the returned output `y` after a programmable settle time, and compares each sample against a parameterised truth table. It reports pass/fail, a mismatch count, the first failing vector and the full captured response. This is hardware that replaces the exhaustive stimulus-and-monitor testbench.

## Interface
- `EXPECTED`, 16'h0DD0, golden truth table; bit `i` = expected `y` for vector `i`, where `i = {a,b,c,d}` and `a` is the MSB. Default encodes F = (A xor B) and (C or not D).
- `SETTLE`, 2, cycles the vector is held before sampling; legal range 1..15.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a sweep.
- `y`  in  1  output of the function under test.
- `a`, `b`, `c`, `d`  out  1 each  registered stimulus to the function under test.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when a sweep ends.
- `pass`  out  1  last sweep had zero mismatches.
- `fail_count`  out  5  mismatches in the last sweep, 0..16.
- `first_fail`  out  4  index of the lowest failing vector.
- `first_fail_vld`  out  1  `first_fail` is meaningful.
- `response`  out  16  captured `y` per vector index.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- **IDLE**
  - `a..d` = 0 and `busy` = 0.
  - `start` = 1 causes the following: vector index `vec` <- 0, settle counter <- 0, result registers cleared (`pass`, `fail_count`, `first_fail`, `first_fail_vld`, `response` all 0), next state DRIVE.
- **DRIVE**
  - `{a,b,c,d}` = `vec`.
  - Settle counter increments each cycle.
  - When the counter reaches `SETTLE-1`, the next state is SAMPLE.
- **SAMPLE**
  - `{a,b,c,d}` remains `vec`.
  - `response[vec]` <- `y`.
  - If `y != EXPECTED[vec]`:
    - `fail_count` increments.
    - If `first_fail_vld` = 0: `first_fail` <- `vec` and `first_fail_vld` <- 1.
  - If `vec` = 15: next state DONE.
  - Otherwise: `vec` increments, counter <- 0, next state DRIVE.
- **DONE**
  - `done` = 1 for exactly this cycle.
  - `pass` <- (final `fail_count` = 0), including the SAMPLE-cycle update.
  - Next state IDLE.
- `busy` = 1 in DRIVE, SAMPLE and DONE.
- `start` is ignored outside IDLE; there is no queuing.
- Results hold from DONE until the next accepted `start`.
- `fail_count` is 5 bits wide so a count of 16 does not wrap.
- `y` is sampled directly. The function under test is combinational, so no synchroniser is used.

## Timing
- Reset: state IDLE; `a..d`, `busy`, `done`, `pass`, `first_fail_vld` = 0; `fail_count`, `first_fail` = 0; `response` = 16'h0000.
- Reset mid-sweep abandons the run immediately. The next cycle shows reset values, and the partial results are lost.
- Let edge 0 be the edge that samples `start`.
  - Vector `i` is driven from edge `1 + i*(SETTLE+1)`.
  - Vector `i` is sampled on edge `(i+1)*(SETTLE+1)`.
  - `done` is high during the cycle after edge `16*(SETTLE+1)`. With `SETTLE` = 2, `done` is visible after edge 48, and `busy` falls after edge 49.
- `start` asserted during the DONE cycle is ignored. The earliest restart is the first IDLE cycle.

## Configuration
- `FN4_CHECK_STOP_ON_FAIL_EN`
  - Defined: a mismatch in SAMPLE goes straight to DONE. Result is `fail_count` = 1, `first_fail` = failing index, and `response` bits above that index = 0. Sweep time shrinks to `(first_fail+1)*(SETTLE+1)` cycles.
  - Undefined: all 16 vectors are always swept, and `fail_count` reports every mismatch.

## Test plan
- Correct function model, `SETTLE` = 2, pulse `start` → `done` one cycle after edge 48, `pass` = 1, `fail_count` = 0, `first_fail_vld` = 0, `response` = 16'h0DD0.
- `y` stuck at 0 → `fail_count` = 6, `first_fail` = 4, `first_fail_vld` = 1, `response` = 16'h0000, `pass` = 0.
- Inverted model (`y` = not F) → `fail_count` = 16, `first_fail` = 0, `response` = 16'hF22F.
- With `FN4_CHECK_STOP_ON_FAIL_EN`, `y` stuck at 0, `SETTLE` = 2 → `done` after edge 15, `fail_count` = 1, `first_fail` = 4, `response` = 16'h0000.
- Assert `rst` while vector 7 is being driven → next cycle all outputs at reset values; a new `start` performs a full 16-vector sweep with correct results.
- Pulse `start` at vector 3 and again during the DONE cycle → both ignored; single `done` pulse; results match a single sweep.
